// File: rtl/pr_pkg.sv
// Shared types for the PageRank write-back stage.
// Holds the FSM state encoding and AXI constants.
package pr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        DONE
    } wb_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int BYTES_PER_BEAT = DATA_W_DEF / 8;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic int bytes_per_beat(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/pr_burst_splitter.sv
// Splits the remaining word count into bursts of at most MAX_BURST beats.
// Produces the burst length and the address/count after this burst.
module pr_burst_splitter
    import pr_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int CNT_W     = 32,
    parameter int MAX_BURST = 16,
    parameter int BYTES     = BYTES_PER_BEAT
) (
    input  logic [CNT_W-1:0]  remaining,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        awlen,
    output logic [CNT_W-1:0]  next_remaining,
    output logic [ADDR_W-1:0] next_addr
);

    localparam int SH = $clog2(BYTES);
    localparam logic [8:0] MB_BEATS = 9'(MAX_BURST);
    localparam logic [7:0] MB_LEN = 8'(MAX_BURST - 1);

    logic [8:0] beats;

    // Clamp to MAX_BURST; a 256-beat tail wraps awlen to 255 as intended.
    always_comb begin
        if (remaining > CNT_W'(MAX_BURST)) begin
            beats = MB_BEATS;
            awlen = MB_LEN;
        end else begin
            beats = remaining[8:0];
            awlen = remaining[7:0] - 8'd1;
        end
        next_remaining = remaining - CNT_W'(beats);
        next_addr = addr + (ADDR_W'(beats) << SH);
    end

endmodule

// File: rtl/pr_write_back_ctrl.sv
// Write-back consumer: pops a start token, drains rank words to memory
// as single-outstanding write bursts, then pulses ap_done.
module pr_write_back_ctrl
    import pr_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 64,
    parameter int CNT_W     = 32,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_empty_n,
    output logic              start_read,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_num_vertices,
    input  logic              rank_empty_n,
    input  logic [DATA_W-1:0] rank_dout,
    output logic              rank_read,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wlast,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              ap_idle,
    output logic              ap_done,
    output logic              err
);

    localparam int BYTES = bytes_per_beat(DATA_W);

    wb_state_e state, state_nxt;

    logic [CNT_W-1:0]  remaining_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        beat_q;
    logic              err_q;

    logic [7:0]        awlen_c;
    logic [CNT_W-1:0]  next_rem;
    logic [ADDR_W-1:0] next_addr;

    pr_burst_splitter #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_BURST),
        .BYTES     (BYTES)
    ) u_split (
        .remaining      (remaining_q),
        .addr           (addr_q),
        .awlen          (awlen_c),
        .next_remaining (next_rem),
        .next_addr      (next_addr)
    );

    // Address and length come from registers that only move in IDLE/B,
    // so they stay stable for the whole AW handshake.
    assign m_awaddr = addr_q;
    assign m_awlen  = awlen_c;
    assign m_wdata  = rank_dout;
    assign err      = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        start_read = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        rank_read  = 1'b0;
        m_wlast    = 1'b0;
        m_bready   = 1'b0;
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        unique case (state)
            IDLE: begin
                ap_idle    = 1'b1;
                start_read = start_empty_n;
                if (start_empty_n) begin
                    if (cfg_num_vertices == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = AW;
                    end
                end
            end
            AW: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    state_nxt = W;
                end
            end
            W: begin
                m_wvalid  = rank_empty_n;
                rank_read = rank_empty_n & m_wready;
                m_wlast   = (beat_q == awlen_c);
                if (rank_empty_n && m_wready && m_wlast) begin
                    state_nxt = B;
                end
            end
            B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    if (next_rem != '0) begin
                        state_nxt = AW;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                ap_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pass bookkeeping: captured config, beat counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            if (state == IDLE && start_empty_n) begin
                remaining_q <= cfg_num_vertices;
                addr_q      <= cfg_base_addr;
            end
            if (state == AW && m_awready) begin
                beat_q <= '0;
            end
            if (state == W && rank_read) begin
                beat_q <= beat_q + 8'd1;
            end
            if (state == B && m_bvalid) begin
                remaining_q <= next_rem;
                addr_q      <= next_addr;
                if (m_bresp != AXI_RESP_OKAY) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pr_write_back_ctrl.sv
// Scoreboard bench for pr_write_back_ctrl: models the start and rank
// FIFOs plus a memory slave, and checks every AW and W handshake.
module tb_pr_write_back_ctrl;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 64;
    localparam int CNT_W     = 32;
    localparam int MAX_BURST = 16;

    logic              clk;
    logic              reset;
    logic              start_empty_n;
    logic              start_read;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [CNT_W-1:0]  cfg_num_vertices;
    logic              rank_empty_n;
    logic [DATA_W-1:0] rank_dout;
    logic              rank_read;
    logic              m_awvalid;
    logic              m_awready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic              m_wvalid;
    logic              m_wready;
    logic [DATA_W-1:0] m_wdata;
    logic              m_wlast;
    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;
    logic              ap_idle;
    logic              ap_done;
    logic              err;

    pr_write_back_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start_empty_n    (start_empty_n),
        .start_read       (start_read),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_num_vertices (cfg_num_vertices),
        .rank_empty_n     (rank_empty_n),
        .rank_dout        (rank_dout),
        .rank_read        (rank_read),
        .m_awvalid        (m_awvalid),
        .m_awready        (m_awready),
        .m_awaddr         (m_awaddr),
        .m_awlen          (m_awlen),
        .m_wvalid         (m_wvalid),
        .m_wready         (m_wready),
        .m_wdata          (m_wdata),
        .m_wlast          (m_wlast),
        .m_bvalid         (m_bvalid),
        .m_bready         (m_bready),
        .m_bresp          (m_bresp),
        .ap_idle          (ap_idle),
        .ap_done          (ap_done),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
    } aw_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } w_t;

    aw_t exp_aw[$];
    w_t  exp_w[$];
    aw_t aw_log[$];
    logic [DATA_W-1:0] rank_q[$];
    int sr_cyc[$];
    int done_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    int done_cnt = 0;

    bit f_w_hs, f_w_last, f_b_hs, f_sr;
    bit hold_aw = 1'b0;
    aw_t held;

    int gap = 0;
    bit toggle = 1'b0;
    int err_idx = -1;
    int resp_idx = 0;
    bit b_pending = 1'b0;
    int gap_cnt = 0;
    int tok_pushed = 0;
    int tok_popped = 0;
    int clr_req = 0;
    int clr_seen = 0;

    // Monitor and scoreboard: everything seen here completes at the next edge.
    always @(negedge clk) begin
        cyc++;
        f_w_hs   = m_wvalid && m_wready;
        f_w_last = m_wlast;
        f_b_hs   = m_bvalid && m_bready;
        f_sr     = start_read;
        if (!reset) begin
            if (hold_aw) begin
                checks++;
                if (!m_awvalid || m_awaddr !== held.addr || m_awlen !== held.len) begin
                    errors++;
                    $display("FAIL aw_stable got v=%0b a=%h l=%0d want a=%h l=%0d",
                             m_awvalid, m_awaddr, m_awlen, held.addr, held.len);
                end
            end
            hold_aw = m_awvalid && !m_awready;
            held = '{m_awaddr, m_awlen};
            if (m_awvalid && m_awready) begin
                aw_cnt++;
                aw_log.push_back('{m_awaddr, m_awlen});
                checks++;
                if (exp_aw.size() == 0) begin
                    errors++;
                    $display("FAIL aw_unexpected got a=%h l=%0d want none", m_awaddr, m_awlen);
                end else begin
                    aw_t e;
                    e = exp_aw.pop_front();
                    if (m_awaddr !== e.addr || m_awlen !== e.len) begin
                        errors++;
                        $display("FAIL aw got a=%h l=%0d want a=%h l=%0d",
                                 m_awaddr, m_awlen, e.addr, e.len);
                    end
                end
            end
            if (m_wvalid && m_wready) begin
                w_cnt++;
                checks++;
                if (exp_w.size() == 0) begin
                    errors++;
                    $display("FAIL w_unexpected got d=%h want none", m_wdata);
                end else begin
                    w_t e;
                    e = exp_w.pop_front();
                    if (m_wdata !== e.data || m_wlast !== e.last) begin
                        errors++;
                        $display("FAIL w_beat got d=%h last=%0b want d=%h last=%0b",
                                 m_wdata, m_wlast, e.data, e.last);
                    end
                end
            end
            if (m_wvalid || rank_read) begin
                checks++;
                if (rank_read !== (m_wvalid && m_wready)) begin
                    errors++;
                    $display("FAIL rank_read got %0b want %0b", rank_read, m_wvalid && m_wready);
                end
            end
            if (m_awvalid || m_wvalid) begin
                checks++;
                if (m_awvalid && m_wvalid) begin
                    errors++;
                    $display("FAIL aw_w_overlap got both valid want exclusive");
                end
            end
            if (start_read) sr_cyc.push_back(cyc);
            if (ap_done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
        end else begin
            hold_aw = 1'b0;
        end
    end

    // Environment model: start FIFO, rank FIFO and memory slave.
    always @(posedge clk) begin
        #1;
        if (f_sr) tok_popped++;
        if (gap_cnt > 0) gap_cnt--;
        if (f_w_hs) begin
            if (rank_q.size() > 0) void'(rank_q.pop_front());
            gap_cnt = gap;
            if (f_w_last) b_pending = 1'b1;
        end
        if (f_b_hs) begin
            b_pending = 1'b0;
            resp_idx++;
        end
        if (clr_seen != clr_req) begin
            clr_seen = clr_req;
            rank_q.delete();
            b_pending = 1'b0;
            gap_cnt = 0;
            tok_popped = tok_pushed;
        end
        m_wready = toggle ? !m_wready : 1'b1;
        m_awready = toggle ? !m_awready : 1'b1;
        m_bvalid = b_pending;
        m_bresp = (resp_idx == err_idx) ? 2'd2 : 2'd0;
        start_empty_n = (tok_pushed > tok_popped);
        rank_empty_n = (rank_q.size() > 0) && (gap_cnt == 0);
        rank_dout = (rank_q.size() > 0) ? rank_q[0] : '0;
    end

    task automatic load_pass(input logic [ADDR_W-1:0] base, input int n);
        int rem;
        int b;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        cfg_base_addr = base;
        cfg_num_vertices = CNT_W'(n);
        rem = n;
        a = base;
        while (rem > 0) begin
            b = (rem > MAX_BURST) ? MAX_BURST : rem;
            exp_aw.push_back('{a, 8'(b - 1)});
            for (int k = 0; k < b; k++) begin
                d = $urandom;
                rank_q.push_back(d);
                exp_w.push_back('{d, (k == b - 1)});
            end
            a = a + ADDR_W'(b * (DATA_W / 8));
            rem = rem - b;
        end
        tok_pushed++;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout got done=%0d want %0d", name, done_cnt, target);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got aw=%0d w=%0d left want 0",
                     name, exp_aw.size(), exp_w.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ap_idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %0b want 1", ap_idle); end
        checks++;
        if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got %0b want 0", m_awvalid); end
        checks++;
        if (m_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %0b want 0", m_wvalid); end
        checks++;
        if (m_bready !== 1'b0) begin errors++; $display("FAIL rst_bready got %0b want 0", m_bready); end
        checks++;
        if (ap_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", ap_done); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", err); end
        checks++;
        if (start_read !== 1'b0 || rank_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_reads got sr=%0b rr=%0b want 0", start_read, rank_read);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int d0 = done_cnt;
        int a0 = aw_cnt;
        int w0 = w_cnt;
        aw_log.delete();
        load_pass(64'h1000, 40);
        wait_done(d0 + 1, 400, "basic");
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
        checks++;
        if (aw_cnt - a0 != 3) begin errors++; $display("FAIL basic_bursts got %0d want 3", aw_cnt - a0); end
        checks++;
        if (w_cnt - w0 != 40) begin errors++; $display("FAIL basic_beats got %0d want 40", w_cnt - w0); end
        checks++;
        if (aw_log.size() != 3 ||
            aw_log[0].addr !== 64'h1000 || aw_log[0].len !== 8'd15 ||
            aw_log[1].addr !== 64'h1040 || aw_log[1].len !== 8'd15 ||
            aw_log[2].addr !== 64'h1080 || aw_log[2].len !== 8'd7) begin
            errors++;
            $display("FAIL basic_aw_list got n=%0d want 0x1000/15 0x1040/15 0x1080/7", aw_log.size());
        end
        check_drained("basic");
    endtask

    task automatic test_zero;
        int d0 = done_cnt;
        int a0 = aw_cnt;
        int w0 = w_cnt;
        int s0 = sr_cyc.size();
        int lat;
        load_pass(64'h2000, 0);
        wait_done(d0 + 1, 50, "zero");
        checks++;
        if (aw_cnt != a0 || w_cnt != w0) begin
            errors++;
            $display("FAIL zero_traffic got aw=%0d w=%0d want 0", aw_cnt - a0, w_cnt - w0);
        end
        lat = (sr_cyc.size() > s0) ? done_cyc[done_cyc.size() - 1] - sr_cyc[s0] : -1;
        checks++;
        if (lat < 1 || lat > 2) begin
            errors++;
            $display("FAIL zero_latency got %0d want 1..2", lat);
        end
        check_drained("zero");
    endtask

    task automatic test_gaps;
        int d0 = done_cnt;
        int w0 = w_cnt;
        gap = 3;
        toggle = 1'b1;
        load_pass(64'h3000, 5);
        wait_done(d0 + 1, 300, "gaps");
        gap = 0;
        toggle = 1'b0;
        checks++;
        if (w_cnt - w0 != 5) begin errors++; $display("FAIL gaps_beats got %0d want 5", w_cnt - w0); end
        check_drained("gaps");
    endtask

    task automatic test_err;
        int d0 = done_cnt;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_pre got %0b want 0", err); end
        err_idx = resp_idx + 1;
        load_pass(64'h4000, 48);
        wait_done(d0 + 1, 500, "err");
        err_idx = -1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err); end
        check_drained("err");
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err); end
    endtask

    task automatic test_back_to_back;
        int d0 = done_cnt;
        int a0 = aw_cnt;
        int s0 = sr_cyc.size();
        int f0 = done_cyc.size();
        load_pass(64'h5000, 3);
        load_pass(64'h5000, 3);
        wait_done(d0 + 2, 200, "b2b");
        checks++;
        if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done got %0d want 2", done_cnt - d0); end
        checks++;
        if (aw_cnt - a0 != 2) begin errors++; $display("FAIL b2b_bursts got %0d want 2", aw_cnt - a0); end
        checks++;
        if (sr_cyc.size() - s0 != 2 || done_cyc.size() - f0 < 1 ||
            sr_cyc[s0 + 1] <= done_cyc[f0]) begin
            errors++;
            $display("FAIL b2b_order got pops=%0d want 2 with second after first done",
                     sr_cyc.size() - s0);
        end
        check_drained("b2b");
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL b2b_err_sticky got %0b want 1", err); end
    endtask

    task automatic test_reset_mid;
        int w0 = w_cnt;
        int n = 0;
        int d0;
        load_pass(64'h6000, 32);
        while (w_cnt - w0 < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (w_cnt - w0 < 6) begin errors++; $display("FAIL rmid_reach got %0d want 6", w_cnt - w0); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ap_idle !== 1'b1 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state got idle=%0b aw=%0b w=%0b b=%0b want 1 0 0 0",
                     ap_idle, m_awvalid, m_wvalid, m_bready);
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got %0b want 0", err); end
        clr_req++;
        @(posedge clk);
        @(posedge clk); #2;
        exp_aw.delete();
        exp_w.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        w0 = w_cnt;
        load_pass(64'h7000, 20);
        wait_done(d0 + 1, 300, "rmid_fresh");
        checks++;
        if (w_cnt - w0 != 20) begin errors++; $display("FAIL rmid_beats got %0d want 20", w_cnt - w0); end
        check_drained("rmid");
    endtask

    initial begin
        reset = 1'b1;
        start_empty_n = 1'b0;
        cfg_base_addr = '0;
        cfg_num_vertices = '0;
        rank_empty_n = 1'b0;
        rank_dout = '0;
        m_awready = 1'b1;
        m_wready = 1'b1;
        m_bvalid = 1'b0;
        m_bresp = 2'd0;
        test_reset();
        test_basic();
        test_zero();
        test_gaps();
        test_err();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
